// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner: per-frame input snapshot,
// anti-ghosting blank slots, decimal points, blanking and leading-zero suppression.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  localparam int unsigned IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END  = CNT_W'(BLANK_LAST);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF    = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_lz;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_tick;

  logic                    w_last_idx;
  logic                    w_end_slot;
  logic                    w_end_blank;
  logic                    w_frame_start;
  logic [IDX_W-1:0]        w_step_idx;
  logic [IDX_W-1:0]        w_tgt_idx;
  logic [4*NUM_DIGITS-1:0] w_src_hex;
  logic [NUM_DIGITS-1:0]   w_src_dp;
  logic [NUM_DIGITS-1:0]   w_src_blank;
  logic                    w_src_lz;
  logic                    w_run;
  logic [NUM_DIGITS-1:0]   w_sup;
  logic [3:0]              w_nib;
  logic                    w_sel_dp;
  logic                    w_sel_blank;
  logic                    w_sel_sup;
  logic [7:0]              w_lit;
  logic [NUM_DIGITS-1:0]   w_an_lit;

  // Hex nibble to lit-segment mask (1 = segment on), bits g..a.
  function automatic logic [6:0] decode_lit(input logic [3:0] nib);
    logic [6:0] al;
    case (nib)
      4'h0: al = 7'b1000000;
      4'h1: al = 7'b1111001;
      4'h2: al = 7'b0100100;
      4'h3: al = 7'b0110000;
      4'h4: al = 7'b0011001;
      4'h5: al = 7'b0010010;
      4'h6: al = 7'b0000010;
      4'h7: al = 7'b1111000;
      4'h8: al = 7'b0000000;
      4'h9: al = 7'b0010000;
      4'hA: al = 7'b0001000;
      4'hB: al = 7'b0000011;
      4'hC: al = 7'b1000110;
      4'hD: al = 7'b0100001;
      4'hE: al = 7'b0000110;
      default: al = 7'b0001110;
    endcase
    return ~al;
  endfunction

  // Slot sequencing, and the lit pattern for whichever digit is shown after this edge.
  always_comb begin
    w_last_idx    = (r_idx == LAST_IDX);
    w_end_slot    = (r_state == S_SHOW) && (r_cnt == LAST_CNT);
    w_end_blank   = (r_state == S_BLANK) && (r_cnt == BLANK_END);
    w_frame_start = en && ((r_state == S_IDLE) || (w_end_slot && w_last_idx));
    w_step_idx    = w_last_idx ? '0 : IDX_W'(r_idx + 1'b1);

    w_tgt_idx = r_idx;
    if (r_state == S_IDLE) begin
      w_tgt_idx = '0;
    end else if (r_state == S_SHOW) begin
      w_tgt_idx = w_step_idx;
    end

    // A frame start with no blank phase lights digit 0 straight from the inputs.
    w_src_hex   = w_frame_start ? hex_in      : r_hex;
    w_src_dp    = w_frame_start ? dp_in       : r_dp;
    w_src_blank = w_frame_start ? blank_in    : r_blank;
    w_src_lz    = w_frame_start ? lz_suppress : r_lz;

    w_run = 1'b1;
    w_sup = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      w_run    = w_run & (w_src_hex[i*4 +: 4] == 4'h0);
      w_sup[i] = w_src_lz & w_run;
    end

    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    w_sel_sup   = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (w_tgt_idx == IDX_W'(i)) begin
        w_nib       = w_src_hex[i*4 +: 4];
        w_sel_dp    = w_src_dp[i];
        w_sel_blank = w_src_blank[i];
        w_sel_sup   = w_sup[i];
      end
    end

    if (w_sel_blank) begin
      w_lit = 8'h00;
    end else if (w_sel_sup) begin
      w_lit = {w_sel_dp, 7'h00};
    end else begin
      w_lit = {w_sel_dp, decode_lit(w_nib)};
    end

    w_an_lit = NUM_DIGITS'(1) << w_tgt_idx;
  end

  // Scan FSM with registered, polarity-adjusted outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_hex   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      r_lz    <= 1'b0;
      r_seg   <= SEG_OFF;
      r_an    <= AN_OFF;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (!en) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_seg   <= SEG_OFF;
        r_an    <= AN_OFF;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            r_idx <= '0;
            if (BLANK_CYCLES == 0) begin
              r_state <= S_SHOW;
              r_seg   <= SEG_OFF ^ w_lit;
              r_an    <= AN_OFF ^ w_an_lit;
            end else begin
              r_state <= S_BLANK;
              r_seg   <= SEG_OFF;
              r_an    <= AN_OFF;
            end
          end
          S_BLANK: begin
            r_cnt <= CNT_W'(r_cnt + 1'b1);
            if (w_end_blank) begin
              r_state <= S_SHOW;
              r_seg   <= SEG_OFF ^ w_lit;
              r_an    <= AN_OFF ^ w_an_lit;
            end
          end
          S_SHOW: begin
            if (w_end_slot) begin
              r_cnt <= '0;
              r_idx <= w_step_idx;
              if (BLANK_CYCLES == 0) begin
                r_seg <= SEG_OFF ^ w_lit;
                r_an  <= AN_OFF ^ w_an_lit;
              end else begin
                r_state <= S_BLANK;
                r_seg   <= SEG_OFF;
                r_an    <= AN_OFF;
              end
            end else begin
              r_cnt <= CNT_W'(r_cnt + 1'b1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_seg   <= SEG_OFF;
            r_an    <= AN_OFF;
          end
        endcase
        if (w_frame_start) begin
          r_hex   <= hex_in;
          r_dp    <= dp_in;
          r_blank <= blank_in;
          r_lz    <= lz_suppress;
          r_tick  <= 1'b1;
        end
      end
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign digit_idx  = r_idx;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a blanked active-low instance and a
// no-blank active-high instance share stimulus; both are checked each cycle.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;

  logic [7:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic [1:0]  idx0, idx1;
  logic        tick0, tick1;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .seg_out(seg0),
    .an_out(an0), .digit_idx(idx0), .frame_tick(tick0)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(0),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .seg_out(seg1),
    .an_out(an1), .digit_idx(idx1), .frame_tick(tick1)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: position within the frame plus the frame's snapshot.
  logic [6:0]  tbl [16];
  bit          m_act [2];
  int          m_t   [2];
  logic [15:0] m_hex [2];
  logic [3:0]  m_dp  [2];
  logic [3:0]  m_bl  [2];
  bit          m_lz  [2];
  int          m_b   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_t[k]   = 0;
      m_hex[k] = '0;
      m_dp[k]  = '0;
      m_bl[k]  = '0;
      m_lz[k]  = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || !en) begin
        m_act[k] = 1'b0;
        m_t[k]   = 0;
      end else begin
        if (!m_act[k]) begin
          m_act[k] = 1'b1;
          m_t[k]   = 0;
        end else begin
          m_t[k] = m_t[k] + 1;
          if (m_t[k] == ND * SD) m_t[k] = 0;
        end
        if (m_t[k] == 0) begin
          m_hex[k] = hex_in;
          m_dp[k]  = dp_in;
          m_bl[k]  = blank_in;
          m_lz[k]  = lz_suppress;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_seg_al(input int k);
    int          i;
    logic [15:0] upper;
    if (!m_act[k] || (m_t[k] % SD) < m_b[k]) return 8'hFF;
    i     = m_t[k] / SD;
    upper = m_hex[k] >> (4 * i);
    if (m_bl[k][i]) return 8'hFF;
    if (m_lz[k] && i > 0 && upper == 16'h0) return {~m_dp[k][i], 7'h7F};
    return {~m_dp[k][i], tbl[upper[3:0]]};
  endfunction

  function automatic logic [3:0] exp_an_al(input int k);
    if (!m_act[k] || (m_t[k] % SD) < m_b[k]) return 4'hF;
    return ~(4'b0001 << (m_t[k] / SD));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] s_hi;
    logic [3:0] a_hi;
    s_hi = ~exp_seg_al(1);
    a_hi = ~exp_an_al(1);
    chk("seg_lo",  32'(seg0),  32'(exp_seg_al(0)));
    chk("an_lo",   32'(an0),   32'(exp_an_al(0)));
    chk("idx_lo",  32'(idx0),  m_act[0] ? 32'(m_t[0] / SD) : 32'd0);
    chk("tick_lo", 32'(tick0), 32'(m_act[0] && m_t[0] == 0));
    chk("seg_hi",  32'(seg1),  32'(s_hi));
    chk("an_hi",   32'(an1),   32'(a_hi));
    chk("idx_hi",  32'(idx1),  m_act[1] ? 32'(m_t[1] / SD) : 32'd0);
    chk("tick_hi", 32'(tick1), 32'(m_act[1] && m_t[1] == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int guard;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_b = '{2, 0};
    model_reset();

    // Reset state
    rst_n = 1'b0; en = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0; lz_suppress = 1'b0;
    #12;
    check_all();
    chk("rst_seg_lo", 32'(seg0), 32'h0000_00FF);
    chk("rst_an_hi",  32'(an1),  32'h0);
    chk("rst_seg_hi", 32'(seg1), 32'h0);
    rst_n = 1'b1;
    run(3);

    // Basic scan of 12AF
    en = 1'b1; hex_in = 16'h12AF;
    run(3);
    chk("s1_seg_F", 32'(seg0), 32'h0000_008E);
    chk("s1_an_d0", 32'(an0),  32'hE);
    run(61);

    // Snapshot holds across a mid-frame input change
    hex_in = 16'h1234;
    run(11);
    hex_in = 16'h5678;
    run(64);

    // Leading-zero suppression
    lz_suppress = 1'b1; hex_in = 16'h0040;
    run(40);
    hex_in = 16'h0000; dp_in = 4'b0010;
    run(64);

    // Decimal point and blanking
    lz_suppress = 1'b0; dp_in = 4'b0100; blank_in = 4'b0001; hex_in = 16'h8888;
    run(64);

    // en dropped in the 4th SHOW cycle of digit 2, then re-asserted
    guard = 0;
    while (m_t[0] != 2 * SD + 2 + 3 && guard < 4 * ND * SD) begin
      step();
      guard++;
    end
    chk("s5_reach", 32'(m_t[0]), 32'(2 * SD + 5));
    en = 1'b0;
    step();
    chk("s5_an_off",  32'(an0),  32'hF);
    chk("s5_seg_off", 32'(seg0), 32'h0000_00FF);
    chk("s5_idx0",    32'(idx0), 32'h0);
    run(2);
    en = 1'b1;
    step();
    chk("s5_tick", 32'(tick0), 32'h1);
    run(40);

    // Randomized traffic, with one asynchronous reset mid-run
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        hex_in      = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp_in       = 4'($urandom);
        blank_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        lz_suppress = 1'($urandom);
      end
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      if (n == 700) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Drives a multiplexed common-anode display of NUM_DIGITS seven-segment digits from a packed hex word. It is the parametrised successor of the single-digit hex decoder and adds digit scanning, per-digit decimal point and blanking, leading-zero suppression, and anti-ghosting blank slots. It sits between the clock/counter datapath and the board display pins. Its outputs are registered and glitch-free.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SCAN_DIV, 100000, clock cycles per digit slot; must satisfy SCAN_DIV > BLANK_CYCLES
BLANK_CYCLES, 4, cycles per slot with all anodes off before the digit is lit; 0 removes the blank phase
SEG_ACTIVE_LOW, 1, 1 means a segment is lit at 0; 0 inverts seg_out
AN_ACTIVE_LOW, 1, 1 means an anode is enabled at 0; 0 inverts an_out

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  1 = scanning; 0 = display dark
hex_in  input  4*NUM_DIGITS  packed nibbles; digit 0 is [3:0] and is the least significant digit
dp_in  input  NUM_DIGITS  decimal point request per digit
blank_in  input  NUM_DIGITS  force digit dark, including its dp
lz_suppress  input  1  blank leading zeros
seg_out  output  8  bit7 = dp, bits 6:0 = g..a
an_out  output  NUM_DIGITS  anode enables, one-hot when lit
digit_idx  output  max(1,clog2(NUM_DIGITS))  index of the current slot
frame_tick  output  1  one-cycle pulse at the start of each frame

Behaviour:
- States: IDLE, BLANK, SHOW. A slot counter counts 0..SCAN_DIV-1.
- Outputs are registered. They change on the same edge that enters the state they belong to.
- Reset (rst_n=0, asynchronous): state=IDLE, digit_idx=0, counter=0, frame_tick=0, snapshot=0, seg_out=all off, an_out=all off. "All off" is 8'hFF and {NUM_DIGITS{1'b1}} at the default polarities.
- IDLE: all outputs off. If en=1, go to BLANK with digit_idx=0. This is a frame start.
- Frame start (entering digit 0's slot):
  - hex_in, dp_in, blank_in and lz_suppress are captured into the snapshot on that edge.
  - frame_tick=1 for exactly that one cycle.
  - All digits of the frame display from the snapshot, so the display never tears.
- BLANK: lasts BLANK_CYCLES cycles (counter 0..BLANK_CYCLES-1). an_out and seg_out are all off. Then go to SHOW.
- SHOW: lasts SCAN_DIV-BLANK_CYCLES cycles. an_out enables only digit_idx; seg_out = decode(snapshot nibble) with dp.
- End of slot: digit_idx increments. After NUM_DIGITS-1 it wraps to 0, which is a new frame start. Next state is BLANK, or SHOW directly if BLANK_CYCLES=0.
- Decode table, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp segment = ~dp (active-low).
- Leading-zero suppression (lz_suppress=1): scanning from digit NUM_DIGITS-1 downward, every digit whose nibble is 0 and whose higher digits are all suppressed is dark. Digit 0 is never suppressed. A suppressed digit's dp is still shown if set.
- Blanked digit (blank_in=1 or suppressed): seg_out all off during SHOW. an_out still enables the digit, which keeps the duty cycle uniform.
- en dropped mid-frame: next edge goes to IDLE, all outputs off, digit_idx=0, counter=0. Re-asserting en starts a fresh frame with a new snapshot.
- Timing: frame length = NUM_DIGITS*SCAN_DIV cycles. frame_tick period is the same.
- Polarity parameters invert only at the output registers. Internal logic is polarity-independent.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 unless stated.
1. Reset, then en=1, hex_in=16'h12AF, dp_in=0 -> frame_tick pulses every 32 cycles. Each slot is 2 cycles of an_out=1111, seg_out=FF, then 6 cycles of:
   - an_out=1110 with seg_out=8'b10001110 (F)
   - then 1101 with 10001000 (A)
   - then 1011 with 10100100 (2)
   - then 0111 with 11111001 (1)
2. hex_in changes from 16'h1234 to 16'h5678 during digit 1's SHOW phase -> digits 1..3 still show 3,2,1. The next frame shows 8,7,6,5.
3. lz_suppress=1, hex_in=16'h0040 -> digits 3 and 2 are dark (seg_out=FF with anode on). Digit 1 shows 4 (10011001) and digit 0 shows 0 (11000000). With hex_in=16'h0000, only digit 0 shows 0.
4. dp_in=4'b0100, blank_in=4'b0001, hex_in=16'h8888:
   - digit 2 shows seg_out=8'b00000000
   - digit 0 shows seg_out=FF
   - digits 1 and 3 show 10000000
5. en deasserted in the 4th cycle of digit 2's SHOW phase -> on the next edge an_out=1111, seg_out=FF, digit_idx=0. Re-assert en -> frame_tick fires on the entry edge.
6. BLANK_CYCLES=0, and AN_ACTIVE_LOW=0 with SEG_ACTIVE_LOW=0 -> no blank phase; an_out is one-hot high for 8 cycles per digit. seg_out for 0 is 8'b00111111. In reset, seg_out=00 and an_out=0000.
